// File: rtl/booth_mult_seq.sv
// booth_mult_seq: iterative radix-4 Booth multiplier with a valid/ack handshake.
// Retires one partial product per clock through a single shared Booth encoder.
// The result holds until the consumer acknowledges it.
// Optional build macro: BOOTH_UNSIGNED_MODE_EN adds a per-operation mult_signed
// input. When mult_signed is 0, both operands are treated as unsigned.
module booth_mult_seq #(
    parameter int WIDTH = 12,
    localparam int RES_W = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mult_1,
    input  logic [WIDTH-1:0] mult_2,
`ifdef BOOTH_UNSIGNED_MODE_EN
    input  logic             mult_signed,
`endif
    output logic [RES_W-1:0] result,
    output logic             result_rdy,
    input  logic             result_ack
);

    // Two guard bits keep the +-2M partial products from overflowing.
    localparam int ACC_W = RES_W + 2;
    // Extended multiplier: two extension bits, the operand, and the appended Booth zero.
    localparam int MW    = WIDTH + 3;
    localparam int CNT_W = $clog2(WIDTH / 2 + 1);
    localparam logic [CNT_W-1:0] LAST_S = CNT_W'(WIDTH / 2 - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [MW-1:0]      m_q, m_d;
    logic [ACC_W-1:0]   mc_q, mc_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               rdy_q, rdy_d;
    logic [CNT_W-1:0]   last;
    logic               sx1, sx2;

`ifdef BOOTH_UNSIGNED_MODE_EN
    // An unsigned operation needs one extra digit to absorb the zero-extended top bit.
    localparam logic [CNT_W-1:0] LAST_U = CNT_W'(WIDTH / 2);
    logic [CNT_W-1:0] last_q, last_d;
    assign last = last_q;
    assign sx1  = mult_signed & mult_1[WIDTH-1];
    assign sx2  = mult_signed & mult_2[WIDTH-1];
`else
    assign last = LAST_S;
    assign sx1  = mult_1[WIDTH-1];
    assign sx2  = mult_2[WIDTH-1];
`endif

    logic [2:0]       grp;
    logic [ACC_W-1:0] pp;
    logic [ACC_W-1:0] acc_next;

    // Booth digit select and shifted accumulate for the current digit.
    always_comb begin
        grp = m_q[{cnt_q, 1'b0} +: 3];
        pp  = '0;
        case (grp)
            3'b001, 3'b010: pp = mc_q;
            3'b011:         pp = mc_q << 1;
            3'b100:         pp = ~(mc_q << 1) + ACC_W'(1);
            3'b101, 3'b110: pp = ~mc_q + ACC_W'(1);
            default:        pp = '0;
        endcase
        acc_next = acc_q + (pp << {cnt_q, 1'b0});
    end

    // Next-state logic: accept in IDLE, one digit per CALC edge, hold in DONE until ack.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        mc_d    = mc_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rdy_d   = rdy_q;
`ifdef BOOTH_UNSIGNED_MODE_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = CALC;
                    m_d     = {{2{sx1}}, mult_1, 1'b0};
                    mc_d    = {{(ACC_W - WIDTH){sx2}}, mult_2};
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef BOOTH_UNSIGNED_MODE_EN
                    last_d  = mult_signed ? LAST_S : LAST_U;
`endif
                end
            end
            CALC: begin
                acc_d = acc_next;
                if (cnt_q == last) begin
                    state_d = DONE;
                    res_d   = acc_next[RES_W-1:0];
                    rdy_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (result_ack) begin
                    state_d = IDLE;
                    rdy_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            mc_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rdy_q   <= 1'b0;
`ifdef BOOTH_UNSIGNED_MODE_EN
            last_q  <= LAST_S;
`endif
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            mc_q    <= mc_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rdy_q   <= rdy_d;
`ifdef BOOTH_UNSIGNED_MODE_EN
            last_q  <= last_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign result     = res_q;
    assign result_rdy = rdy_q;

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised, iterative radix-4 Booth multiplier for the FFT butterfly datapath.
- Successor to the fixed 12-bit, six-instance Booth top.
- Generic WIDTH; one partial product per clock through a single shared Booth encoder.
- Proper two-sided handshake: input accept, output hold until acknowledged.
- Sits between the twiddle ROM / sample buffer and the butterfly adder stage.

Parameters:
- WIDTH, 12, operand width in bits; must be even and at least 4.
- RES_W, 2*WIDTH, result width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start request; operands valid this cycle
- in_ready  out  1  block idle and able to accept (state IDLE)
- mult_1  in  WIDTH  multiplier, Booth-recoded, two's complement
- mult_2  in  WIDTH  multiplicand, two's complement
- result  out  RES_W  product, two's complement
- result_rdy  out  1  result valid; held until acknowledged
- result_ack  in  1  consumer acknowledge

Behaviour:
- Reset: state=IDLE, result=0, result_rdy=0, iteration counter=0, accumulator=0. in_ready=1 while in reset and after release.
- States:
  - IDLE: on en=1, go to CALC. In the same edge, latch mult_1 as {mult_1,1'b0}, sign-extend mult_2 to RES_W+2 bits, clear the accumulator, set cnt=0.
  - CALC: each edge, decode group g = {m[2cnt+2], m[2cnt+1], m[2cnt]} of the latched extended multiplier:
    - 000/111 -> +0
    - 001/010 -> +M
    - 011 -> +2M
    - 100 -> -2M
    - 101/110 -> -M
    - The partial product is shifted left by 2*cnt, added to the accumulator, then cnt increments.
    - When cnt reaches LAST (WIDTH/2-1), go to DONE in that same edge, result<=acc_next[RES_W-1:0], result_rdy<=1.
  - DONE: result and result_rdy hold. On result_ack=1, go to IDLE and clear result_rdy; result keeps its value.
- Latency: result_rdy rises WIDTH/2 edges after the accepting edge (6 for WIDTH=12). Throughput is one product per WIDTH/2+2 cycles with immediate ack.
- in_ready is combinational: (state==IDLE).
- en while not IDLE: ignored, no queueing.
- Operands changing during CALC: no effect, since operands are latched.
- result_ack outside DONE: ignored.
- result_ack and en together in DONE: ack only; en is not accepted until the next IDLE cycle.
- Reset mid-CALC or mid-DONE: immediate return to reset values; the partial product is discarded.
- Arithmetic:
  - The accumulator is RES_W+2 bits so that ±2M never overflows.
  - The output is truncated to RES_W bits, which is exact for all signed WIDTH×WIDTH products, including (-2^(W-1))².
  - -M and -2M use two's complement (invert plus 1) on the extended multiplicand.

Optional Feature:
- Macro BOOTH_UNSIGNED_MODE_EN.
- Defined:
  - Adds input port mult_signed (1 bit), sampled with en.
  - mult_signed=0 treats both operands as unsigned: zero-extend mult_2, zero-extend the multiplier by 2 bits, LAST=WIDTH/2, latency WIDTH/2+1.
  - mult_signed=1 gives signed behaviour exactly as above.
- Undefined: no mult_signed port; always signed; LAST=WIDTH/2-1.

Test Plan:
- WIDTH=12: reset, release, then en with mult_1=3, mult_2=5 -> in_ready drops next cycle; result_rdy high exactly 6 edges after accept; result=0x00000F; held until result_ack.
- Corner signed values (WIDTH=12), each followed by an ack:
  - -2048×-2048 -> 0x400000
  - 2047×-2048 -> 0xC00800
  - -1×1 -> 0xFFFFFF
  - 0×-2048 -> 0x000000
- Back-to-back: assert en and result_ack every cycle -> accept only in IDLE cycles; operands changed mid-CALC do not alter the result; en in DONE is not accepted.
- Assert rst_n=0 at the 3rd CALC edge -> result=0, result_rdy=0, in_ready=1 immediately. A new 7×-9 after release gives 0xFFFFC1.
- Random sweep, 10k pairs, WIDTH=8 and WIDTH=16 -> result equals signed reference product; latency always WIDTH/2.
- With BOOTH_UNSIGNED_MODE_EN, WIDTH=12, mult_signed=0, 4095×4095 -> 0xFFE001 after 7 edges. With mult_signed=1, the same operands give 0x000001.
